ads1115_i2c_target: RTL and testbench

ADS1115_I2C_TARGET -- requirements
Module: ads1115_i2c_target

---
 rtl/ads1115_pkg.sv | 36 +++
 rtl/i2c_bus_sync.sv | 46 ++++
 rtl/ads1115_i2c_target.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ads1115_i2c_target.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads1115_pkg.sv
// ads1115_pkg
// Shared definitions for the ADS1115-style I2C register target:
//   - default 7-bit bus address
//   - register pointer encodings
//   - register reset values
//   - protocol FSM state enum
package ads1115_pkg;

    localparam logic [6:0] DEFAULT_ADDR = 7'h48;

    // Register pointer encodings (low two bits of the pointer byte)
    localparam logic [1:0] PTR_CONV = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;
    localparam logic [1:0] PTR_LO   = 2'd2;
    localparam logic [1:0] PTR_HI   = 2'd3;

    // Register reset values
    localparam logic [15:0] CONV_RST = 16'h0000;
    localparam logic [15:0] CFG_RST  = 16'h8583;
    localparam logic [15:0] LO_RST   = 16'h8000;
    localparam logic [15:0] HI_RST   = 16'h7FFF;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WR_BYTE   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_BYTE   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
// Brings the raw I2C lines into the clk domain and derives bus events.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   scl, sda_in : raw bus lines
//   sda         : synchronized SDA level
//   scl_rise    : one-cycle pulse on synchronized SCL rising edge
//   scl_fall    : one-cycle pulse on synchronized SCL falling edge
//   start_det   : SDA fell while SCL high
//   stop_det    : SDA rose while SCL high
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0],[1] form the 2-FF synchronizer, [2] holds the previous synced value.
    // Reset to 1 (idle bus) so no spurious START is seen coming out of reset.
    logic [2:0] scl_p;
    logic [2:0] sda_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_p <= 3'b111;
            sda_p <= 3'b111;
        end else begin
            scl_p <= {scl_p[1:0], scl};
            sda_p <= {sda_p[1:0], sda_in};
        end
    end

    assign sda       = sda_p[1];
    assign scl_rise  =  scl_p[1] & ~scl_p[2];
    assign scl_fall  = ~scl_p[1] &  scl_p[2];
    // SCL must be high on both samples so an SDA change around an SCL edge
    // is never mistaken for START/STOP.
    assign start_det = scl_p[1] & scl_p[2] &  sda_p[2] & ~sda_p[1];
    assign stop_det  = scl_p[1] & scl_p[2] & ~sda_p[2] &  sda_p[1];

endmodule

// File: rtl/ads1115_i2c_target.sv
// ads1115_i2c_target
// I2C target exposing the ADS1115 register map: conversion (read-only),
// config, lo_thresh and hi_thresh. The target never stretches SCL.
// Optional feature macro: ADS1115_COMPARATOR_EN
//   defined   : threshold registers are R/W and alert_n implements the
//               traditional comparator
//   undefined : pointers 2/3 read 0, writes to them are dropped, alert_n = 1
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   scl, sda_in : raw I2C bus lines
//   sda_oe      : 1 = pull SDA low, 0 = release
//   conv_data   : signed conversion result, captured on conv_valid
//   conv_valid  : one-cycle strobe
//   cfg_reg     : current config register
//   cfg_wr      : one-cycle pulse the cycle after cfg_reg is written
//   alert_n     : active-low comparator alert
// Handshake: conv_valid is a qualifier-only strobe (no ready); conv_data is
// captured on every cycle conv_valid is high.
module ads1115_i2c_target
    import ads1115_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = DEFAULT_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] conv_data,
    input  logic        conv_valid,
    output logic [15:0] cfg_reg,
    output logic        cfg_wr,
    output logic        alert_n
);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t      state;
    logic [3:0]  bit_cnt;     // SCL rises seen in the current byte; 8 = complete
    logic [7:0]  shreg;
    logic        rw;
    logic [1:0]  ptr;
    logic [1:0]  wr_cnt;      // data bytes accepted since the pointer byte
    logic [7:0]  wr_msb;
    logic [15:0] snap;        // read snapshot, isolates reads from conv updates
    logic        byte_sel;    // 0 = sending MSB byte, 1 = LSB byte
    logic        host_nack;
    logic [15:0] conv_q;
    logic [15:0] cfg_q;
    logic        cfg_upd;

`ifdef ADS1115_COMPARATOR_EN
    logic [15:0] lo_q;
    logic [15:0] hi_q;
`endif

    logic        byte_done;
    logic [15:0] rd_sel;
    logic [7:0]  tx_byte;
    logic [7:0]  next_byte;
    logic        tx_bit;

    assign byte_done = bit_cnt[3];
    assign cfg_reg   = cfg_q;

    always_comb begin
        rd_sel = conv_q;
        case (ptr)
            PTR_CFG: rd_sel = cfg_q;
`ifdef ADS1115_COMPARATOR_EN
            PTR_LO:  rd_sel = lo_q;
            PTR_HI:  rd_sel = hi_q;
`else
            PTR_LO:  rd_sel = 16'h0000;
            PTR_HI:  rd_sel = 16'h0000;
`endif
            default: rd_sel = conv_q;
        endcase
    end

    always_comb begin
        tx_byte   = byte_sel ? snap[7:0]  : snap[15:8];
        next_byte = byte_sel ? snap[15:8] : snap[7:0];
        // bit_cnt rises already seen -> next bit to present is 7 - bit_cnt
        tx_bit    = tx_byte[3'd7 - bit_cnt[2:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            rw        <= 1'b0;
            ptr       <= PTR_CONV;
            wr_cnt    <= 2'd0;
            wr_msb    <= 8'h00;
            snap      <= 16'h0000;
            byte_sel  <= 1'b0;
            host_nack <= 1'b0;
            sda_oe    <= 1'b0;
            conv_q    <= CONV_RST;
            cfg_q     <= CFG_RST;
            cfg_upd   <= 1'b0;
            cfg_wr    <= 1'b0;
`ifdef ADS1115_COMPARATOR_EN
            lo_q      <= LO_RST;
            hi_q      <= HI_RST;
`endif
        end else begin
            cfg_upd <= 1'b0;
            cfg_wr  <= cfg_upd;

            if (conv_valid) begin
                conv_q <= conv_data;
            end

            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                // Any half-received write is simply abandoned here.
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WR_BYTE: begin
                        shreg   <= {shreg[6:0], sda};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    ST_RD_BYTE: bit_cnt   <= bit_cnt + 4'd1;
                    ST_RD_ACK:  host_nack <= sda;
                    default: ;
                endcase
            end else if (scl_fall) begin
                // All SDA drive changes happen here, with SCL already low.
                case (state)
                    ST_ADDR: begin
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            if (shreg[7:1] == I2C_ADDR) begin
                                rw       <= shreg[0];
                                sda_oe   <= 1'b1;
                                snap     <= rd_sel;
                                byte_sel <= 1'b0;
                                state    <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                            sda_oe <= ~snap[15];
                            state  <= ST_RD_BYTE;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= ST_PTR;
                        end
                    end
                    ST_PTR: begin
                        if (byte_done) begin
                            ptr     <= shreg[1:0];
                            wr_cnt  <= 2'd0;
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b1;
                            state   <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WR_ACK: begin
                        sda_oe <= 1'b0;
                        state  <= ST_WR_BYTE;
                    end
                    ST_WR_BYTE: begin
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            if (wr_cnt == 2'd2) begin
                                // Third data byte: leave SDA released (NACK).
                                state <= ST_WAIT_STOP;
                            end else begin
                                sda_oe <= 1'b1;
                                wr_cnt <= wr_cnt + 2'd1;
                                state  <= ST_WR_ACK;
                                if (wr_cnt == 2'd0) begin
                                    wr_msb <= shreg;
                                end else begin
                                    case (ptr)
                                        PTR_CFG: begin
                                            cfg_q   <= {wr_msb, shreg};
                                            cfg_upd <= 1'b1;
                                        end
`ifdef ADS1115_COMPARATOR_EN
                                        PTR_LO: lo_q <= {wr_msb, shreg};
                                        PTR_HI: hi_q <= {wr_msb, shreg};
`endif
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                            state   <= ST_RD_ACK;
                        end else begin
                            sda_oe <= ~tx_bit;
                        end
                    end
                    ST_RD_ACK: begin
                        bit_cnt <= 4'd0;
                        if (host_nack) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WAIT_STOP;
                        end else begin
                            byte_sel <= ~byte_sel;
                            sda_oe   <= ~next_byte[7];
                            state    <= ST_RD_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ADS1115_COMPARATOR_EN
    // Traditional comparator with hysteresis; cfg_reg[1:0] = 11 disables it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alert_n <= 1'b1;
        end else if (cfg_q[1:0] == 2'b11) begin
            alert_n <= 1'b1;
        end else if (conv_valid) begin
            if ($signed(conv_data) > $signed(hi_q)) begin
                alert_n <= 1'b0;
            end else if ($signed(conv_data) < $signed(lo_q)) begin
                alert_n <= 1'b1;
            end
        end
    end
`else
    assign alert_n = 1'b1;
`endif

endmodule

// File: tb/tb_ads1115_i2c_target.sv
`timescale 1ns/1ps
module tb_ads1115_i2c_target;

    localparam logic [6:0] ADDR = 7'h48;
    localparam int Q = 8;  // clk cycles per quarter SCL period

`ifdef ADS1115_COMPARATOR_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_scl = 1'b1;
    logic        host_sda = 1'b1;
    logic        bus_sda;
    logic        sda_oe;
    logic [15:0] conv_data = 16'h0000;
    logic        conv_valid = 1'b0;
    logic [15:0] cfg_reg;
    logic        cfg_wr;
    logic        alert_n;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and target
    assign bus_sda = host_sda & ~sda_oe;

    ads1115_i2c_target #(.I2C_ADDR(ADDR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl        (host_scl),
        .sda_in     (bus_sda),
        .sda_oe     (sda_oe),
        .conv_data  (conv_data),
        .conv_valid (conv_valid),
        .cfg_reg    (cfg_reg),
        .cfg_wr     (cfg_wr),
        .alert_n    (alert_n)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- monitors ----------------
    int          cyc = 0;
    int          cfg_wr_cnt = 0;
    int          cfg_chg_cyc = -10;
    int          wr_gap_bad = 0;
    bit          oe_seen = 1'b0;
    logic [15:0] cfg_prev = 16'hxxxx;

    always @(negedge clk) begin
        cyc++;
        if (sda_oe) oe_seen = 1'b1;
        if (cfg_wr) begin
            cfg_wr_cnt++;
            if (cyc != cfg_chg_cyc + 1) wr_gap_bad++;
        end
        if (cfg_reg !== cfg_prev) cfg_chg_cyc = cyc;
        cfg_prev = cfg_reg;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within 5 ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [15:0] m_reg [4];
    logic [1:0]  m_ptr;
    int          m_cfg_wr = 0;
    logic        m_alert;

    task automatic m_reset();
        m_reg[0] = 16'h0000;
        m_reg[1] = 16'h8583;
        m_reg[2] = 16'h8000;
        m_reg[3] = 16'h7FFF;
        m_ptr    = 2'd0;
        m_alert  = 1'b1;
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] p);
        if (p >= 2'd2 && !COMP) return 16'h0000;
        return m_reg[p];
    endfunction

    task automatic m_commit(input logic [15:0] v);
        case (m_ptr)
            2'd1: begin
                m_reg[1] = v;
                m_cfg_wr++;
                if (v[1:0] == 2'b11) m_alert = 1'b1;
            end
            2'd2, 2'd3: if (COMP) m_reg[m_ptr] = v;
            default: ;
        endcase
    endtask

    task automatic m_conv(input logic [15:0] v);
        m_reg[0] = v;
        if (COMP) begin
            if (m_reg[1][1:0] == 2'b11) m_alert = 1'b1;
            else if ($signed(v) > $signed(m_reg[3])) m_alert = 1'b0;
            else if ($signed(v) < $signed(m_reg[2])) m_alert = 1'b1;
        end
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic qwait();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        host_sda = 1'b1; qwait();
        host_scl = 1'b1; qwait();
        host_sda = 1'b0; qwait();
        host_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        host_sda = 1'b0; qwait();
        host_scl = 1'b1; qwait();
        host_sda = 1'b1; qwait();
    endtask

    task automatic send_bit(input logic b);
        host_sda = b;    qwait();
        host_scl = 1'b1; qwait(); qwait();
        host_scl = 1'b0; qwait();
    endtask

    task automatic recv_bit(output logic b);
        host_sda = 1'b1; qwait();
        host_scl = 1'b1; qwait();
        b = bus_sda;     qwait();
        host_scl = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic pulse_conv(input logic [15:0] v);
        conv_data  = v;
        conv_valid = 1'b1;
        @(posedge clk); #1;
        conv_valid = 1'b0;
        m_conv(v);
    endtask

    // Write: address, pointer byte, then n data bytes (host stops at a NACK)
    task automatic host_write(input logic [6:0] a7, input logic [7:0] pb, input int n,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input bit do_stop);
        logic       ack;
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        i2c_start();
        send_byte({a7, 1'b0}, ack);
        chk("wr_addr_ack", 16'(ack), 16'(a7 == ADDR));
        if (ack) begin
            send_byte(pb, ack);
            chk("wr_ptr_ack", 16'(ack), 16'd1);
            m_ptr = pb[1:0];
            for (int i = 0; i < n; i++) begin
                send_byte(d[i], ack);
                chk("wr_data_ack", 16'(ack), 16'(i < 2));
                if (i == 1) m_commit({d[0], d[1]});
                if (!ack) break;
            end
        end
        if (do_stop) i2c_stop();
    endtask

    // Read nbytes from the current pointer; optional conv strobe after byte 0
    task automatic host_read(input int nbytes, input bit do_conv, input logic [15:0] conv_mid);
        logic        ack;
        logic [7:0]  d;
        logic [15:0] s;
        i2c_start();
        send_byte({ADDR, 1'b1}, ack);
        chk("rd_addr_ack", 16'(ack), 16'd1);
        s = m_read(m_ptr);
        for (int i = 0; i < nbytes; i++) begin
            if (do_conv && i == 1) pulse_conv(conv_mid);
            recv_byte(d, i != nbytes - 1);
            chk("rd_byte", 16'(d), 16'((i % 2 == 0) ? s[15:8] : s[7:0]));
        end
        i2c_stop();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic        ack;
        logic [15:0] v;
        int          op;
        int          n;
        logic [1:0]  p;

        m_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sda_oe", 16'(sda_oe), 16'd0);
        chk("rst_cfg", cfg_reg, 16'h8583);
        chk("rst_cfg_wr", 16'(cfg_wr), 16'd0);
        chk("rst_alert", 16'(alert_n), 16'd1);
        rst_n = 1'b1;
        qwait();

        // Partial 16-bit write abandoned by STOP
        host_write(ADDR, 8'h01, 1, 8'hAA, 8'h00, 8'h00, 1'b1);
        qwait();
        chk("partial_cfg", cfg_reg, 16'h8583);
        chk("partial_cfg_wr", 16'(cfg_wr_cnt), 16'd0);

        // Config write
        host_write(ADDR, 8'h01, 2, 8'h84, 8'h83, 8'h00, 1'b1);
        qwait();
        chk("cfg_write", cfg_reg, 16'h8483);
        chk("cfg_wr_once", 16'(cfg_wr_cnt), 16'd1);

        // Conversion read with an update during the read
        pulse_conv(16'h1234);
        host_write(ADDR, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b1);
        host_read(2, 1'b1, 16'h5678);
        host_read(2, 1'b0, 16'h0000);

        // Wrong address: never drives SDA
        oe_seen = 1'b0;
        host_write(7'h49, 8'h01, 2, 8'h11, 8'h22, 8'h00, 1'b1);
        qwait();
        chk("nack_oe", 16'(oe_seen), 16'd0);
        chk("nack_cfg", cfg_reg, m_reg[1]);

        // Third data byte NACKed, first two committed; read wraps via repeated START
        host_write(ADDR, 8'h01, 3, 8'h05, 8'h42, 8'h99, 1'b1);
        qwait();
        chk("three_byte_cfg", cfg_reg, 16'h0542);
        host_write(ADDR, 8'h01, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        host_read(3, 1'b0, 16'h0000);

`ifdef ADS1115_COMPARATOR_EN
        host_write(ADDR, 8'h03, 2, 8'h01, 8'h00, 8'h00, 1'b1);
        host_write(ADDR, 8'h01, 2, 8'h85, 8'h80, 8'h00, 1'b1);
        pulse_conv(16'h0200);
        chk("alert_hi", 16'(alert_n), 16'd0);
        pulse_conv(16'h7000);
        chk("alert_hold", 16'(alert_n), 16'd0);
        host_write(ADDR, 8'h02, 2, 8'h00, 8'h50, 8'h00, 1'b1);
        pulse_conv(16'h0010);
        chk("alert_lo", 16'(alert_n), 16'd1);
        host_write(ADDR, 8'h02, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        host_read(2, 1'b0, 16'h0000);
`else
        host_write(ADDR, 8'h02, 2, 8'h12, 8'h34, 8'h00, 1'b1);
        host_read(2, 1'b0, 16'h0000);
        host_write(ADDR, 8'h03, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        host_read(2, 1'b0, 16'h0000);
        pulse_conv(16'h7FFF);
        chk("alert_off", 16'(alert_n), 16'd1);
`endif

        // Randomized transactions against the model
        for (int it = 0; it < 8; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    v = 16'($urandom);
                    if (v == m_reg[1]) v = v ^ 16'h0001;
                    host_write(ADDR, 8'h01, 2, v[15:8], v[7:0], 8'h00, 1'b1);
                end
                1: begin
                    pulse_conv(16'($urandom));
                    host_write(ADDR, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b0);
                    host_read(2, 1'b1, 16'($urandom));
                end
                2: begin
                    p = 2'($urandom_range(0, 3));
                    host_write(ADDR, {6'($urandom), p}, 0, 8'h00, 8'h00, 8'h00, 1'b0);
                    host_read(int'($urandom_range(1, 4)), 1'b0, 16'h0000);
                end
                default: begin
                    p = 2'($urandom_range(0, 3));
                    n = int'($urandom_range(1, 3));
                    v = 16'($urandom);
                    if (p == 2'd1 && v == m_reg[1]) v = v ^ 16'h0001;
                    host_write(ADDR, {6'd0, p}, n, v[15:8], v[7:0], 8'($urandom), 1'b1);
                end
            endcase
            qwait();
            chk("rnd_cfg", cfg_reg, m_reg[1]);
            chk("rnd_alert", 16'(alert_n), 16'(m_alert));
        end

        // Reset in the middle of a config read
        host_write(ADDR, 8'h01, 2, 8'h12, 8'h34, 8'h00, 1'b1);
        host_write(ADDR, 8'h01, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        i2c_start();
        send_byte({ADDR, 1'b1}, ack);
        chk("mid_rd_ack", 16'(ack), 16'd1);
        chk("mid_rd_drive", 16'(sda_oe), 16'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_oe", 16'(sda_oe), 16'd0);
        chk("mid_rst_cfg", cfg_reg, 16'h8583);
        repeat (3) @(posedge clk);
        #1;
        m_reset();
        rst_n = 1'b1;
        qwait();
        i2c_stop();
        host_read(2, 1'b0, 16'h0000);
        host_write(ADDR, 8'h01, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        host_read(2, 1'b0, 16'h0000);

        qwait();
        chk("cfg_wr_count", 16'(cfg_wr_cnt), 16'(m_cfg_wr));
        chk("cfg_wr_timing", 16'(wr_gap_bad), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
